// File: rtl/aud_player.sv
// aud_player: I2S DACDAT transmitter streaming 16-bit PCM words from SRAM, MSB first, left channel.
// Build option AUD_PLAYER_MONO_DUP_EN: resend each word on the right half-frame as well.
module aud_player #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_dac_data,
  output logic              o_done
);

  // state    | meaning
  // S_IDLE   | stopped, address parked at 0
  // S_WAIT   | armed, load word on next LRC fall
  // S_SEND   | shifting the left word
  // S_HOLD   | word finished, waiting for next frame edge
  // S_PAUSE  | paused, address held for resume
  // S_DONE   | end address played
  // S_SEND_R | shifting the duplicated right word (mono dup builds only)
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

`ifdef AUD_PLAYER_MONO_DUP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SEND, S_HOLD, S_PAUSE, S_DONE, S_SEND_R
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SEND, S_HOLD, S_PAUSE, S_DONE
  } state_t;
`endif

  state_t            state;
  logic              lrc_d;
  logic              pause_pending;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              fall;
  logic              last_word;
  logic              pause_now;

  // lrc_d also provides the one-BCLK I2S data delay after the LRC edge
  assign fall      = lrc_d & ~i_lrc;
  assign last_word = (o_address == i_end_addr);
  assign pause_now = pause_pending | i_pause;

`ifdef AUD_PLAYER_MONO_DUP_EN
  logic rise;
  logic right_due;
  assign rise = ~lrc_d & i_lrc;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      o_address     <= '0;
      o_dac_data    <= 1'b0;
      o_done        <= 1'b0;
      lrc_d         <= 1'b1;
      cnt           <= '0;
      shreg         <= '0;
      pause_pending <= 1'b0;
`ifdef AUD_PLAYER_MONO_DUP_EN
      right_due     <= 1'b0;
`endif
    end else begin
      lrc_d <= i_lrc;
      if (i_stop) begin
        state         <= S_IDLE;
        o_address     <= '0;
        o_dac_data    <= 1'b0;
        o_done        <= 1'b0;
        cnt           <= '0;
        pause_pending <= 1'b0;
`ifdef AUD_PLAYER_MONO_DUP_EN
        right_due     <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start && !i_pause) state <= S_WAIT;
          end
          S_WAIT: begin
            if (i_pause) begin
              state <= S_PAUSE;
            end else if (fall) begin
              o_dac_data <= i_sram_data[DATA_W-1];
              shreg      <= {i_sram_data[DATA_W-2:0], 1'b0};
              cnt        <= CNT_W'(1);
              state      <= S_SEND;
            end
          end
          S_SEND: begin
            if (i_pause) pause_pending <= 1'b1;
            if (cnt == CNT_LAST) begin
              o_dac_data <= 1'b0;
              cnt        <= '0;
`ifdef AUD_PLAYER_MONO_DUP_EN
              state      <= S_HOLD;
              right_due  <= 1'b1;
`else
              if (last_word) begin
                state  <= S_DONE;
                o_done <= 1'b1;
              end else begin
                o_address <= o_address + ADDR_W'(1);
                state     <= pause_now ? S_PAUSE : S_HOLD;
              end
              pause_pending <= 1'b0;
`endif
            end else begin
              o_dac_data <= shreg[DATA_W-1];
              shreg      <= {shreg[DATA_W-2:0], 1'b0};
              cnt        <= cnt + CNT_W'(1);
            end
          end
`ifdef AUD_PLAYER_MONO_DUP_EN
          S_SEND_R: begin
            if (i_pause) pause_pending <= 1'b1;
            if (cnt == CNT_LAST) begin
              o_dac_data <= 1'b0;
              cnt        <= '0;
              if (last_word) begin
                state  <= S_DONE;
                o_done <= 1'b1;
              end else begin
                o_address <= o_address + ADDR_W'(1);
                state     <= pause_now ? S_PAUSE : S_HOLD;
              end
              pause_pending <= 1'b0;
            end else begin
              o_dac_data <= shreg[DATA_W-1];
              shreg      <= {shreg[DATA_W-2:0], 1'b0};
              cnt        <= cnt + CNT_W'(1);
            end
          end
          // address is still on the left word, so SRAM data is re-read for the right copy
          S_HOLD: begin
            if (i_pause) begin
              state         <= S_PAUSE;
              right_due     <= 1'b0;
              pause_pending <= 1'b0;
            end else if (right_due && rise) begin
              o_dac_data <= i_sram_data[DATA_W-1];
              shreg      <= {i_sram_data[DATA_W-2:0], 1'b0};
              cnt        <= CNT_W'(1);
              right_due  <= 1'b0;
              state      <= S_SEND_R;
            end else if (!right_due && fall) begin
              o_dac_data <= i_sram_data[DATA_W-1];
              shreg      <= {i_sram_data[DATA_W-2:0], 1'b0};
              cnt        <= CNT_W'(1);
              state      <= S_SEND;
            end
          end
`else
          S_HOLD: begin
            if (i_pause) begin
              state <= S_PAUSE;
            end else if (fall) begin
              o_dac_data <= i_sram_data[DATA_W-1];
              shreg      <= {i_sram_data[DATA_W-2:0], 1'b0};
              cnt        <= CNT_W'(1);
              state      <= S_SEND;
            end
          end
`endif
          S_PAUSE: begin
            if (i_start && !i_pause) state <= S_WAIT;
          end
          S_DONE: begin
            if (i_start && !i_pause) begin
              state     <= S_WAIT;
              o_address <= '0;
              o_done    <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: scoreboard bench for aud_player; expected DACDAT bits are queued as LRC frames are driven.
module tb_aud_player;
  localparam int H = 20;
`ifdef AUD_PLAYER_MONO_DUP_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lrc;
  logic        start;
  logic        pause;
  logic        stop;
  logic [19:0] end_addr;
  logic [19:0] address;
  logic [15:0] sram_data;
  logic        dac_data;
  logic        done;
  logic [15:0] mem [0:7];
  logic        exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign sram_data = mem[address[2:0]];

  aud_player dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_lrc       (lrc),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_end_addr  (end_addr),
    .i_sram_data (sram_data),
    .o_address   (address),
    .o_dac_data  (dac_data),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dac", {31'b0, dac_data}, {31'b0, e});
    end
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic gap(input int n, input bit do_start);
    for (int i = 0; i < n; i++) begin
      step();
      exp_q.push_back(1'b0);
      lrc = 1'b1;
      if (i == 0 && do_start) start = 1'b1;
    end
  endtask

  // one LRC frame: left half low, right half high; pulse indexes count negedges from the fall
  task automatic frame(input logic [15:0] w, input bit send, input int pause_n,
                       input int stop_n, input int rst_at);
    logic e;
    int   m;
    for (int n = 0; n < 2*H; n++) begin
      step();
      m = n + 1;
      e = 1'b0;
      if (send && m <= 16) e = w[4'(16 - m)];
      if (send && MONO && m >= H + 1 && m <= H + 16) e = w[4'(H + 16 - m)];
      if (stop_n >= 0 && m > stop_n) e = 1'b0;
      if (rst_at >= 0 && m > rst_at) e = 1'b0;
      exp_q.push_back(e);
      lrc = (n < H) ? 1'b0 : 1'b1;
      if (n == pause_n) pause = 1'b1;
      if (n == stop_n) stop = 1'b1;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dac", {31'b0, dac_data}, 32'h0);
        chk("rst_mid_addr", {12'b0, address}, 32'h0);
        chk("rst_mid_done", {31'b0, done}, 32'h0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lrc = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    end_addr = 20'd2;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    mem[0] = 16'hA5C3;
    mem[1] = 16'h8001;
    mem[2] = 16'h7FFE;
    repeat (3) @(negedge clk);
    chk("reset_addr", {12'b0, address}, 32'h0);
    chk("reset_dac", {31'b0, dac_data}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;

    // three words, stop at end address
    gap(2, 1'b1);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    chk("t1_addr0", {12'b0, address}, 32'd1);
    frame(16'h8001, 1'b1, -1, -1, -1);
    chk("t1_addr1", {12'b0, address}, 32'd2);
    chk("t1_notdone", {31'b0, done}, 32'h0);
    frame(16'h7FFE, 1'b1, -1, -1, -1);
    chk("t1_done", {31'b0, done}, 32'h1);
    chk("t1_addr2", {12'b0, address}, 32'd2);
    frame(16'h0, 1'b0, -1, -1, -1);
    chk("t1_done_hold", {31'b0, done}, 32'h1);
    chk("t1_addr_hold", {12'b0, address}, 32'd2);

    // pause mid-word 1, resume at address 2
    gap(2, 1'b1);
    chk("t2_restart_done", {31'b0, done}, 32'h0);
    chk("t2_restart_addr", {12'b0, address}, 32'h0);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    frame(16'h8001, 1'b1, 5, -1, -1);
    chk("t2_pause_addr", {12'b0, address}, 32'd2);
    chk("t2_pause_done", {31'b0, done}, 32'h0);
    frame(16'h0, 1'b0, -1, -1, -1);
    chk("t2_paused_addr", {12'b0, address}, 32'd2);
    gap(2, 1'b1);
    frame(16'h7FFE, 1'b1, -1, -1, -1);
    chk("t2_done", {31'b0, done}, 32'h1);

    // stop mid-word 0, replay from 0
    gap(2, 1'b1);
    frame(16'hA5C3, 1'b1, -1, 8, -1);
    chk("t3_stop_addr", {12'b0, address}, 32'h0);
    chk("t3_stop_done", {31'b0, done}, 32'h0);
    gap(2, 1'b1);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    frame(16'h8001, 1'b1, -1, -1, -1);
    chk("t3_replay_addr", {12'b0, address}, 32'd2);

    // pause and stop together: stop wins, word truncated
    frame(16'h7FFE, 1'b1, 6, 6, -1);
    chk("t5_prio_addr", {12'b0, address}, 32'h0);
    chk("t5_prio_done", {31'b0, done}, 32'h0);
    frame(16'h0, 1'b0, -1, -1, -1);

    // end address 0: exactly one word
    end_addr = 20'd0;
    gap(2, 1'b1);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    chk("t4_done", {31'b0, done}, 32'h1);
    chk("t4_addr", {12'b0, address}, 32'h0);
    frame(16'h0, 1'b0, -1, -1, -1);
    gap(2, 1'b1);
    chk("t4_restart_done", {31'b0, done}, 32'h0);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    chk("t4_done_again", {31'b0, done}, 32'h1);

    // reset asserted mid-word with a non-zero address
    end_addr = 20'd2;
    gap(2, 1'b1);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    frame(16'h8001, 1'b1, -1, -1, -1);
    frame(16'h7FFE, 1'b1, -1, -1, 8);
    rst_n = 1'b1;
    gap(2, 1'b1);
    frame(16'hA5C3, 1'b1, -1, -1, -1);
    chk("t5_after_rst_addr", {12'b0, address}, 32'd1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
